// File: rtl/pwm_duty_slew.sv
// Duty-cycle slew limiter: moves the applied PWM duty toward the requested target
// by step_size every step_period clocks, with bypass, enable gating and a landing pulse.
module pwm_duty_slew #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   target_duty,
    input  logic [WIDTH-1:0]   step_size,
    input  logic [PRESC_W-1:0] step_period,
    output logic [WIDTH-1:0]   duty_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    localparam logic [PRESC_W-1:0] P_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
    localparam logic [PRESC_W-1:0] P_ZERO = {PRESC_W{1'b0}};
    localparam logic [WIDTH-1:0]   D_ZERO = {WIDTH{1'b0}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRESC_W-1:0] r_tick_cnt;
    logic [PRESC_W-1:0] w_tick_nxt;
    logic [PRESC_W-1:0] w_period_eff;
    logic [WIDTH-1:0]   r_duty;
    logic [WIDTH-1:0]   w_duty_nxt;
    logic [WIDTH-1:0]   w_step_duty;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               r_busy;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_tick_hit;
    logic               w_go_up;

    // Step arithmetic in WIDTH+1 bits so neither direction can wrap past the target.
    always_comb begin
        w_period_eff = (step_period == P_ZERO) ? P_ONE : step_period;
        // >= rather than == so a shortened period mid-ramp fires immediately.
        w_tick_hit   = (r_tick_cnt >= (w_period_eff - P_ONE));
        w_go_up      = (target_duty > r_duty);
        w_sum        = {1'b0, r_duty} + {1'b0, step_size};
        w_diff       = {1'b0, r_duty} - {1'b0, step_size};
        w_step_duty  = r_duty;
        if (w_go_up) begin
            if (w_sum >= {1'b0, target_duty}) begin
                w_step_duty = target_duty;
            end else begin
                w_step_duty = w_sum[WIDTH-1:0];
            end
        end else begin
            if (w_diff[WIDTH] || (w_diff <= {1'b0, target_duty})) begin
                w_step_duty = target_duty;
            end else begin
                w_step_duty = w_diff[WIDTH-1:0];
            end
        end
    end

    // Next-state, tick counter, duty and landing pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_duty_nxt  = r_duty;
        w_done_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_tick_nxt  = P_ZERO;
            w_duty_nxt  = D_ZERO;
        end else if (step_size == D_ZERO) begin
            w_state_nxt = IDLE;
            w_tick_nxt  = P_ZERO;
            w_duty_nxt  = target_duty;
        end else begin
            case (r_state)
                IDLE: begin
                    if (target_duty != r_duty) begin
                        w_state_nxt = w_go_up ? RAMP_UP : RAMP_DOWN;
                        w_tick_nxt  = P_ZERO;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (target_duty == r_duty) begin
                        w_state_nxt = IDLE;
                        w_tick_nxt  = P_ZERO;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = w_go_up ? RAMP_UP : RAMP_DOWN;
                        if (w_tick_hit) begin
                            w_tick_nxt = P_ZERO;
                            w_duty_nxt = w_step_duty;
                            if (w_step_duty == target_duty) begin
                                w_state_nxt = IDLE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_done_nxt  = 1'b0;
                            end
                        end else begin
                            w_tick_nxt = r_tick_cnt + P_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_tick_nxt  = P_ZERO;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tick_cnt <= P_ZERO;
            r_duty     <= D_ZERO;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_duty     <= w_duty_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_done     <= w_done_nxt;
        end
    end

    assign duty_out = r_duty;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_pwm_duty_slew.sv
// Table-driven bench for pwm_duty_slew: per-cycle vectors with hand-derived expectations,
// expected outputs queued at drive time and popped after the clock edge.
module tb_pwm_duty_slew;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  tgt;
        logic [7:0]  step;
        logic [15:0] per;
        logic [7:0]  exp_duty;
        logic        exp_busy;
        logic        exp_done;
        string       name;
    } vec_t;

    typedef struct {
        logic [7:0] duty;
        logic       busy;
        logic       done;
        string      name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  target_duty;
    logic [7:0]  step_size;
    logic [15:0] step_period;
    logic [7:0]  duty_out;
    logic        busy;
    logic        done;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    pwm_duty_slew #(.WIDTH(8), .PRESC_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .target_duty(target_duty),
        .step_size(step_size), .step_period(step_period),
        .duty_out(duty_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic e, input int t, input int s,
                                input int p, input int d, input logic b, input logic dn,
                                input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.tgt = 8'(t); v.step = 8'(s); v.per = 16'(p);
        v.exp_duty = 8'(d); v.exp_busy = b; v.exp_done = dn; v.name = nm;
        tbl.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        exp_t x;
        exp_t got;
        rst = v.rst; en = v.en; target_duty = v.tgt; step_size = v.step; step_period = v.per;
        x.duty = v.exp_duty; x.busy = v.exp_busy; x.done = v.exp_done; x.name = v.name;
        sb.push_back(x);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        n_checks++;
        if (duty_out !== got.duty || busy !== got.busy || done !== got.done) begin
            n_errors++;
            $display("FAIL %s: got duty=%0d busy=%b done=%b, want duty=%0d busy=%b done=%b",
                     got.name, duty_out, busy, done, got.duty, got.busy, got.done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; en = 1'b0; target_duty = 8'd0; step_size = 8'd0; step_period = 16'd0;

        // reset state
        add(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, "reset0");
        add(1'b1, 1'b1, 77, 0, 0, 0, 1'b0, 1'b0, "reset_priority");
        // basic ramp 0 -> 100, step 10, period 4: first step after 5 edges, lands after 41
        add(1'b0, 1'b1, 0, 10, 4, 0, 1'b0, 1'b0, "idle_at_target");
        for (int k = 0; k <= 40; k++)
            add(1'b0, 1'b1, 100, 10, 4, 10 * (k / 4), (k < 40), (k == 40), $sformatf("ramp_up_k%0d", k));
        add(1'b0, 1'b1, 100, 10, 4, 100, 1'b0, 1'b0, "ramp_up_settled");
        // reset mid-ramp 100 -> 200
        for (int k = 0; k <= 4; k++)
            add(1'b0, 1'b1, 200, 10, 4, (k == 4) ? 110 : 100, 1'b1, 1'b0, $sformatf("pre_rst_k%0d", k));
        add(1'b1, 1'b1, 200, 10, 4, 0, 1'b0, 1'b0, "rst_mid_ramp");
        add(1'b0, 1'b0, 0, 10, 4, 0, 1'b0, 1'b0, "en_low_clear");
        // clamp: target 25, step 10, period 1
        add(1'b0, 1'b1, 25, 10, 1, 0, 1'b1, 1'b0, "clamp_enter");
        add(1'b0, 1'b1, 25, 10, 1, 10, 1'b1, 1'b0, "clamp_10");
        add(1'b0, 1'b1, 25, 10, 1, 20, 1'b1, 1'b0, "clamp_20");
        add(1'b0, 1'b1, 25, 10, 1, 25, 1'b0, 1'b1, "clamp_25_done");
        add(1'b0, 1'b1, 25, 10, 1, 25, 1'b0, 1'b0, "clamp_done_1cyc");
        // saturation: bypass to 250, then step 200 toward 255
        add(1'b0, 1'b1, 250, 0, 1, 250, 1'b0, 1'b0, "bypass_250");
        add(1'b0, 1'b1, 255, 200, 1, 250, 1'b1, 1'b0, "sat_enter");
        add(1'b0, 1'b1, 255, 200, 1, 255, 1'b0, 1'b1, "sat_255_done");
        add(1'b0, 1'b1, 255, 200, 1, 255, 1'b0, 1'b0, "sat_settled");
        // bypass and period 0
        add(1'b0, 1'b1, 180, 0, 7, 180, 1'b0, 1'b0, "bypass_180");
        add(1'b0, 1'b1, 180, 0, 7, 180, 1'b0, 1'b0, "bypass_hold");
        add(1'b0, 1'b1, 160, 5, 0, 180, 1'b1, 1'b0, "p0_enter");
        for (int k = 1; k <= 3; k++)
            add(1'b0, 1'b1, 160, 5, 0, 180 - 5 * k, 1'b1, 1'b0, $sformatf("p0_down_k%0d", k));
        add(1'b0, 1'b1, 160, 5, 0, 160, 1'b0, 1'b1, "p0_land");
        add(1'b0, 1'b1, 160, 5, 0, 160, 1'b0, 1'b0, "p0_settled");
        // reversal: bypass to 40, ramp up toward 100 to 60, then target 30
        add(1'b0, 1'b1, 40, 0, 2, 40, 1'b0, 1'b0, "rev_bypass_40");
        add(1'b0, 1'b1, 100, 10, 2, 40, 1'b1, 1'b0, "rev_enter");
        add(1'b0, 1'b1, 100, 10, 2, 40, 1'b1, 1'b0, "rev_t1");
        add(1'b0, 1'b1, 100, 10, 2, 50, 1'b1, 1'b0, "rev_50");
        add(1'b0, 1'b1, 100, 10, 2, 50, 1'b1, 1'b0, "rev_50b");
        add(1'b0, 1'b1, 100, 10, 2, 60, 1'b1, 1'b0, "rev_60");
        add(1'b0, 1'b1, 30, 10, 2, 60, 1'b1, 1'b0, "rev_switch");
        add(1'b0, 1'b1, 30, 10, 2, 50, 1'b1, 1'b0, "rev_dn50");
        add(1'b0, 1'b1, 30, 10, 2, 50, 1'b1, 1'b0, "rev_dn50b");
        add(1'b0, 1'b1, 30, 10, 2, 40, 1'b1, 1'b0, "rev_dn40");
        add(1'b0, 1'b1, 30, 10, 2, 40, 1'b1, 1'b0, "rev_dn40b");
        add(1'b0, 1'b1, 30, 10, 2, 30, 1'b0, 1'b1, "rev_land30");
        add(1'b0, 1'b1, 30, 10, 2, 30, 1'b0, 1'b0, "rev_settled");
        // enable drop at 70, then re-ramp 0 -> 70 with step 35, period 3
        add(1'b0, 1'b1, 70, 0, 3, 70, 1'b0, 1'b0, "en_bypass_70");
        add(1'b0, 1'b0, 70, 35, 3, 0, 1'b0, 1'b0, "en_drop");
        for (int k = 0; k <= 6; k++)
            add(1'b0, 1'b1, 70, 35, 3, 35 * (k / 3), (k < 6), (k == 6), $sformatf("en_ramp_k%0d", k));
        add(1'b0, 1'b1, 70, 35, 3, 70, 1'b0, 1'b0, "en_settled");
        // period shrinks below tick_cnt+1 mid-ramp: step fires on the next edge
        add(1'b0, 1'b0, 0, 10, 8, 0, 1'b0, 1'b0, "shrink_clear");
        for (int k = 0; k <= 4; k++)
            add(1'b0, 1'b1, 50, 10, 8, 0, 1'b1, 1'b0, $sformatf("shrink_tick_k%0d", k));
        add(1'b0, 1'b1, 50, 10, 2, 10, 1'b1, 1'b0, "shrink_fire");
        add(1'b0, 1'b1, 50, 10, 2, 10, 1'b1, 1'b0, "shrink_wait");
        add(1'b0, 1'b1, 50, 10, 2, 20, 1'b1, 1'b0, "shrink_next");

        foreach (tbl[i]) apply(tbl[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
